// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access type encodings,
// controller state enum and lane helper functions.
package lsu_pkg;

  // Access type encodings carried in sltype[2:0]
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    RESP = 2'b11
  } lsu_state_e;

  // Byte mask of an access of the given size code, anchored at lane 0
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // 011, 110 and 111 have no meaning as access types
  function automatic logic type_legal(input logic [2:0] t);
    logic ok;
    case (t)
      3'b011, 3'b110, 3'b111: ok = 1'b0;
      default:                ok = 1'b1;
    endcase
    return ok;
  endfunction

  // True when the access spills past the end of its 32-bit word
  function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] nbytes;
    case (sz)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    return (({1'b0, off} + nbytes) > 3'd4);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request, response and memory-bus signals of the load/store unit.
//   req_*  : core request (valid/ready handshake), byte address, data, type
//   rsp_*  : one-cycle completion pulse with extended load data and error
//   mem_*  : word-addressed memory transaction, held until mem_ack
// slave  : the load/store unit side
// master : the environment (core + memory) side
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sltype;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_sltype, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_sltype, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of right-aligned load data.
//   sel  : access type (sltype[2:0])
//   din  : merged load data, valid bytes at the bottom
//   dout : extended result; 0 for undefined types
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Pick extension width and kind from the access type
  always_comb begin
    dout = 32'h0000_0000;
    case (sel)
      LS_B:    dout = {{24{din[7]}}, din[7:0]};
      LS_H:    dout = {{16{din[15]}}, din[15:0]};
      LS_W:    dout = din;
      LS_BU:   dout = {24'h00_0000, din[7:0]};
      LS_HU:   dout = {16'h0000, din[15:0]};
      default: dout = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed core loads/stores into one or two
// word-aligned memory transactions and returns extended load data.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : load_store_unit_if.slave (core request/response, memory bus)
//   SPLIT_EN : 1 = split word-crossing accesses in two, 0 = reject them
// "Misaligned" here means an access that crosses a word boundary; an access
// that fits inside one word is always served with a single transaction.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input logic                clk,
  input logic                rst,
  load_store_unit_if.slave   bus
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sltype_q, sltype_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  // In IDLE the lanes are computed from the incoming request so ACC0 can
  // start with registered bus outputs; afterwards from the captured request.
  logic [31:0] src_addr_s, src_wdata_s;
  logic [3:0]  src_type_s;
  logic [1:0]  off_s;
  logic [7:0]  be_wide_s;
  logic [63:0] wdata_wide_s;
  logic [31:0] lo_s, hi_s, merged_s, ext_s;
  logic        finish_s;

  assign src_addr_s  = (state_q == IDLE) ? bus.req_addr   : addr_q;
  assign src_wdata_s = (state_q == IDLE) ? bus.req_wdata  : wdata_q;
  assign src_type_s  = (state_q == IDLE) ? bus.req_sltype : sltype_q;
  assign off_s       = src_addr_s[1:0];

  // Low half feeds the first word, high half the spill into the next word
  assign be_wide_s    = {4'b0000, size_mask(src_type_s[1:0])} << off_s;
  assign wdata_wide_s = {32'h0000_0000, src_wdata_s} << {off_s, 3'b000};

  assign lo_s     = bus.mem_rdata >> {addr_q[1:0], 3'b000};
  assign hi_s     = bus.mem_rdata << {3'd4 - {1'b0, addr_q[1:0]}, 3'b000};
  assign merged_s = (state_q == ACC1) ? (rdata_q | hi_s) : lo_s;

  lsu_extend u_extend (
    .sel  (sltype_q[2:0]),
    .din  (merged_s),
    .dout (ext_s)
  );

  // Next-state and next-output computation for the access controller
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sltype_d    = sltype_q;
    rdata_d     = rdata_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    finish_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          sltype_d    = bus.req_sltype;
          rdata_d     = 32'h0000_0000;
          req_ready_d = 1'b0;
          if (!type_legal(bus.req_sltype[2:0]) ||
              (!SPLIT_EN && crosses_word(off_s, bus.req_sltype[1:0]))) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ACC0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_sltype[3];
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_be_d    = be_wide_s[3:0];
            mem_wdata_d = wdata_wide_s[31:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
        if (bus.mem_ack) begin
          rdata_d = lo_s;
          if (crosses_word(addr_q[1:0], sltype_q[1:0])) begin
            state_d     = ACC1;
            mem_addr_d  = {addr_q[31:2], 2'b00} + 32'd4;
            mem_be_d    = be_wide_s[7:4];
            mem_wdata_d = wdata_wide_s[63:32];
          end else begin
            finish_s = 1'b1;
          end
        end else begin
          state_d = ACC0;
        end
      end
      ACC1: begin
        if (bus.mem_ack) begin
          rdata_d  = merged_s;
          finish_s = 1'b1;
        end else begin
          state_d = ACC1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_req_d   = 1'b0;
      end
    endcase

    if (finish_s) begin
      state_d     = RESP;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = 32'h0000_0000;
      mem_be_d    = 4'b0000;
      mem_wdata_d = 32'h0000_0000;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = sltype_q[3] ? 32'h0000_0000 : ext_s;
    end else begin
      finish_s = 1'b0;
    end
  end

  // State and registered outputs; reset abandons any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      sltype_q    <= 4'h0;
      rdata_q     <= 32'h0000_0000;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sltype_q    <= sltype_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for reset,
// spurious ack and the non-splitting variant, then random accesses checked
// against a byte-level memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();
  load_store_unit_if bus2 ();

  load_store_unit #(.SPLIT_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  load_store_unit #(.SPLIT_EN(1'b0)) dut_nosplit (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sltype;
    logic [31:0] w0;
    logic [31:0] w1;
    int          waits;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_n;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    int          lat;
  } vec_t;

  int checks = 0;
  int failures = 0;

  txn_t txq[$];
  txn_t expq[$];
  logic [31:0] mem_words [bit [31:0]];
  logic [7:0]  ref_bytes [bit [31:0]];
  int   fixed_wait = 0;
  bit   spurious = 1'b0;
  bit   busy = 1'b0;
  int   waits_left = 0;
  txn_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return init_word(a);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] ba);
    logic [31:0] w;
    if (ref_bytes.exists(ba)) return ref_bytes[ba];
    w = init_word({ba[31:2], 2'b00});
    return w[8*ba[1:0] +: 8];
  endfunction

  task automatic preset(input logic [31:0] a, input logic [31:0] w);
    mem_words[a] = w;
    for (int b = 0; b < 4; b++) ref_bytes[a + 32'(b)] = w[8*b +: 8];
  endtask

  // Memory responder, run once per cycle just after the rising edge
  task automatic service();
    logic [31:0] w;
    if (rst) begin
      bus.mem_ack = 1'b0;
      busy = 1'b0;
      return;
    end
    if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (bus.mem_req) begin
      if (!busy) begin
        busy = 1'b1;
        waits_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        cur.we = bus.mem_we;
        cur.addr = bus.mem_addr;
        cur.be = bus.mem_be;
        cur.wdata = bus.mem_wdata;
      end else begin
        check("mem_stable_addr", bus.mem_addr, cur.addr);
        check("mem_stable_be", 32'(bus.mem_be), 32'(cur.be));
        check("mem_stable_wdata", bus.mem_wdata, cur.wdata);
        check("mem_stable_we", 32'(bus.mem_we), 32'(cur.we));
      end
      if (waits_left == 0) begin
        bus.mem_rdata = rd_word(cur.addr);
        if (cur.we) begin
          w = rd_word(cur.addr);
          for (int b = 0; b < 4; b++) if (cur.be[b]) w[8*b +: 8] = cur.wdata[8*b +: 8];
          mem_words[cur.addr] = w;
        end
        bus.mem_ack = 1'b1;
        busy = 1'b0;
        txq.push_back(cur);
      end else begin
        waits_left--;
      end
    end else if (spurious) begin
      bus.mem_ack = 1'b1;
      bus.mem_rdata = $urandom;
      spurious = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    service();
  endtask

  // Issue one request and wait (bounded) for its completion pulse
  task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] t, output logic [31:0] rdata,
                           output logic err, output int lat);
    bit seen;
    txq.delete();
    bus.req_valid = 1'b1;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.req_sltype = t;
    cycle();
    bus.req_valid = 1'b0;
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        cycle();
        lat++;
      end
    end
    check("rsp_seen", 32'(seen), 32'd1);
    rdata = bus.rsp_rdata;
    err = bus.rsp_err;
    cycle();
    check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    check("ready_after", 32'(bus.req_ready), 32'd1);
  endtask

  // Byte-level reference: which bytes are touched, and what a load returns
  task automatic ref_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] t, output logic [31:0] exp_rdata,
                            output logic exp_err);
    logic [2:0]  k;
    int          size;
    logic [31:0] val;
    logic [31:0] ba, wa;
    txn_t        e;
    k = t[2:0];
    val = 32'h0;
    exp_rdata = 32'h0;
    expq.delete();
    exp_err = (k == 3'b011) || (k == 3'b110) || (k == 3'b111);
    if (exp_err) return;
    size = (k[1:0] == 2'b00) ? 1 : (k[1:0] == 2'b01) ? 2 : 4;
    e.we = t[3]; e.addr = 32'h0; e.be = 4'h0; e.wdata = 32'h0;
    for (int i = 0; i < size; i++) begin
      ba = addr + 32'(i);
      wa = {ba[31:2], 2'b00};
      if (i == 0) e.addr = wa;
      else if (wa != e.addr) begin
        expq.push_back(e);
        e.addr = wa; e.be = 4'h0; e.wdata = 32'h0;
      end
      e.be[ba[1:0]] = 1'b1;
      if (t[3]) begin
        e.wdata[8*ba[1:0] +: 8] = wdata[8*i +: 8];
        ref_bytes[ba] = wdata[8*i +: 8];
      end else begin
        val[8*i +: 8] = ref_byte(ba);
      end
    end
    expq.push_back(e);
    if (!t[3]) begin
      if (size == 1)      exp_rdata = k[2] ? {24'h0, val[7:0]} : {{24{val[7]}}, val[7:0]};
      else if (size == 2) exp_rdata = k[2] ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
      else                exp_rdata = val;
    end
  endtask

  vec_t vecs[13];

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat;
    bit          reached;
    logic [31:0] mask;

    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.req_sltype = 4'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    bus2.req_valid = 1'b0; bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
    bus2.req_sltype = 4'h0; bus2.mem_ack = 1'b0; bus2.mem_rdata = 32'h0;

    vecs[0]  = '{32'h0000_0100, 32'h0, 4'b0010, 32'hDEAD_BEEF, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 4};
    vecs[1]  = '{32'h0000_0103, 32'h0, 4'b0000, 32'h80FF_FFFF, 32'h0, 0, 32'hFFFF_FF80, 1'b0, 1, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 2};
    vecs[2]  = '{32'h0000_0103, 32'h0, 4'b0100, 32'h80FF_FFFF, 32'h0, 0, 32'h0000_0080, 1'b0, 1, 32'h100, 4'h8, 32'h0, 32'h0, 4'h0, 32'h0, 2};
    vecs[3]  = '{32'h0000_0102, 32'hAABB_CCDD, 4'b1010, 32'h0, 32'h0, 1, 32'h0, 1'b0, 2, 32'h100, 4'hC, 32'hCCDD_0000, 32'h104, 4'h3, 32'h0000_AABB, 6};
    vecs[4]  = '{32'hFFFF_FFFF, 32'h0, 4'b0001, 32'h1234_5678, 32'h9ABC_DE80, 0, 32'hFFFF_8012, 1'b0, 2, 32'hFFFF_FFFC, 4'h8, 32'h0, 32'h0, 4'h1, 32'h0, 4};
    vecs[5]  = '{32'h0000_0100, 32'h0, 4'b0111, 32'h0, 32'h0, 0, 32'h0, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1};
    vecs[6]  = '{32'h0000_0102, 32'h0, 4'b0001, 32'h7FFF_1234, 32'h0, 0, 32'h0000_7FFF, 1'b0, 1, 32'h100, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 2};
    vecs[7]  = '{32'h0000_0101, 32'h0, 4'b0101, 32'h11AB_CD22, 32'h0, 3, 32'h0000_ABCD, 1'b0, 1, 32'h100, 4'h6, 32'h0, 32'h0, 4'h0, 32'h0, 5};
    vecs[8]  = '{32'h0000_0101, 32'h0000_00EE, 4'b1000, 32'h0, 32'h0, 0, 32'h0, 1'b0, 1, 32'h100, 4'h2, 32'h0000_EE00, 32'h0, 4'h0, 32'h0, 2};
    vecs[9]  = '{32'h0000_0100, 32'h0, 4'b0110, 32'h0, 32'h0, 0, 32'h0, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1};
    vecs[10] = '{32'h0000_010D, 32'h0, 4'b0010, 32'h4433_2211, 32'h8877_6655, 0, 32'h5544_3322, 1'b0, 2, 32'h10C, 4'hE, 32'h0, 32'h110, 4'h1, 32'h0, 4};
    vecs[11] = '{32'h0000_0100, 32'h1234_5678, 4'b1011, 32'h0, 32'h0, 0, 32'h0, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0, 1};
    vecs[12] = '{32'h0000_0103, 32'h0000_1234, 4'b1001, 32'h0, 32'h0, 0, 32'h0, 1'b0, 2, 32'h100, 4'h8, 32'h3400_0000, 32'h104, 4'h1, 32'h0000_0012, 4};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b0;
    cycle();
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Directed vector table
    foreach (vecs[i]) begin
      if (vecs[i].exp_n != 0) begin
        preset({vecs[i].addr[31:2], 2'b00}, vecs[i].w0);
        preset({vecs[i].addr[31:2], 2'b00} + 32'd4, vecs[i].w1);
      end
      fixed_wait = vecs[i].waits;
      do_access(vecs[i].addr, vecs[i].wdata, vecs[i].sltype, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_ntxn", i), 32'(txq.size()), 32'(vecs[i].exp_n));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      if (txq.size() >= 1 && vecs[i].exp_n >= 1) begin
        check($sformatf("v%0d_a0", i), txq[0].addr, vecs[i].a0);
        check($sformatf("v%0d_be0", i), 32'(txq[0].be), 32'(vecs[i].be0));
        check($sformatf("v%0d_wd0", i), txq[0].wdata, vecs[i].wd0);
        check($sformatf("v%0d_we0", i), 32'(txq[0].we), 32'(vecs[i].sltype[3]));
      end
      if (txq.size() >= 2 && vecs[i].exp_n >= 2) begin
        check($sformatf("v%0d_a1", i), txq[1].addr, vecs[i].a1);
        check($sformatf("v%0d_be1", i), 32'(txq[1].be), 32'(vecs[i].be1));
        check($sformatf("v%0d_wd1", i), txq[1].wdata, vecs[i].wd1);
      end
    end

    // Ack while no transaction is pending must be ignored
    spurious = 1'b1;
    cycle();
    cycle();
    check("spur_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("spur_mem_req", 32'(bus.mem_req), 32'd0);
    check("spur_req_ready", 32'(bus.req_ready), 32'd1);

    // Reset while the second half of a split access is waiting
    preset(32'hFFFF_FFFC, 32'h1234_5678);
    preset(32'h0000_0000, 32'h9ABC_DE80);
    fixed_wait = 10;
    txq.delete();
    bus.req_valid = 1'b1; bus.req_addr = 32'hFFFF_FFFF; bus.req_sltype = 4'b0001;
    cycle();
    bus.req_valid = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      if (txq.size() == 1 && bus.mem_req && bus.mem_addr == 32'h0) reached = 1'b1;
      else cycle();
    end
    check("acc1_wrap_reached", 32'(reached), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_mid_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    fixed_wait = 0;
    preset(32'h0000_0100, 32'h0BAD_CAFE);
    do_access(32'h0000_0100, 32'h0, 4'b0010, rd, er, lat);
    check("post_rst_lw", rd, 32'h0BAD_CAFE);
    check("post_rst_err", 32'(er), 32'd0);
    check("post_rst_ntxn", 32'(txq.size()), 32'd1);

    // Non-splitting variant: word-crossing access is rejected without a transaction
    bus2.req_valid = 1'b1; bus2.req_addr = 32'hFFFF_FFFF; bus2.req_sltype = 4'b0001;
    cycle();
    bus2.req_valid = 1'b0;
    check("ns_rsp_valid", 32'(bus2.rsp_valid), 32'd1);
    check("ns_rsp_err", 32'(bus2.rsp_err), 32'd1);
    check("ns_mem_req", 32'(bus2.mem_req), 32'd0);
    check("ns_rdata", bus2.rsp_rdata, 32'd0);
    cycle();
    check("ns_pulse", 32'(bus2.rsp_valid), 32'd0);
    check("ns_mem_req2", 32'(bus2.mem_req), 32'd0);
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h0000_0100; bus2.req_sltype = 4'b0010;
    cycle();
    bus2.req_valid = 1'b0;
    check("ns_lw_req", 32'(bus2.mem_req), 32'd1);
    check("ns_lw_addr", bus2.mem_addr, 32'h100);
    check("ns_lw_be", 32'(bus2.mem_be), 32'hF);
    bus2.mem_ack = 1'b1; bus2.mem_rdata = 32'hCAFE_F00D;
    cycle();
    bus2.mem_ack = 1'b0;
    check("ns_lw_valid", 32'(bus2.rsp_valid), 32'd1);
    check("ns_lw_rdata", bus2.rsp_rdata, 32'hCAFE_F00D);
    check("ns_lw_err", 32'(bus2.rsp_err), 32'd0);
    cycle();

    // Random accesses against the byte-level model
    fixed_wait = -1;
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a, wd;
      logic [3:0]  t;
      a  = (($urandom_range(0, 1) == 0) ? 32'h0000_0200 : 32'hFFFF_FFF8) + 32'($urandom_range(0, 15));
      wd = $urandom;
      t  = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      ref_access(a, wd, t, exp_rd, exp_er);
      do_access(a, wd, t, rd, er, lat);
      check("rnd_rdata", rd, exp_rd);
      check("rnd_err", 32'(er), 32'(exp_er));
      check("rnd_ntxn", 32'(txq.size()), 32'(expq.size()));
      for (int j = 0; j < expq.size() && j < txq.size(); j++) begin
        check("rnd_addr", txq[j].addr, expq[j].addr);
        check("rnd_be", 32'(txq[j].be), 32'(expq[j].be));
        check("rnd_we", 32'(txq[j].we), 32'(expq[j].we));
        if (expq[j].we) begin
          mask = {{8{expq[j].be[3]}}, {8{expq[j].be[2]}}, {8{expq[j].be[1]}}, {8{expq[j].be[0]}}};
          check("rnd_wdata", txq[j].wdata & mask, expq[j].wdata);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
